instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
- Front-end fetch unit of the Tomasulo core. Drives the instruction memory's PC and stall inputs, and captures the 16-bit word the memory returns one clock later.
- Captured words are decoded into op/rd/rs1/rs2 and buffered in a small FIFO.
- Decoded instructions are presented to the reservation-station issue logic over a valid/ready handshake.
- This block is the consumer/initiator side of the PC -> instruction memory interface.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, >= 2).
- PROG_LEN, 6, number of instructions fetched per run (1..16).
- PC_W, 4, PC width.
- INSTR_W, 16, instruction width.

Ports:
- clk1 in 1: single clock, all state on posedge.
- rst_n in 1: asynchronous active-low reset.
- start in 1: pulse; begins a run at PC 0 (honoured in IDLE/DONE only).
- flush in 1: synchronous abort; clears everything and returns to IDLE.
- pc out PC_W: fetch address to the instruction memory.
- fetch_stall out 1: 0 = memory latches mem[pc] this edge; 1 = memory holds its output.
- instr_in in INSTR_W: memory output word.
- issue_valid out 1: queue head valid.
- issue_ready in 1: issue logic accepts the head.
- issue_op out 4: instr[15:12]; 0000 add, 0001 sub, 0010 mul.
- issue_rs1 out 4: instr[11:8].
- issue_rs2 out 4: instr[7:4].
- issue_rd out 4: instr[3:0].
- illegal out 1: sticky; a fetched opcode was not add/sub/mul.
- done out 1: run complete and queue drained.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=0; inflight=0; count=0; head/tail=0.
  - Outputs: fetch_stall=1, issue_valid=0, issue_* = 0, illegal=0, done=0.
- FSM:
  - IDLE: start -> FETCH.
  - FETCH: once the word at pc=PROG_LEN-1 has fired -> DRAIN.
  - DRAIN: when inflight==0 and count==0 -> DONE.
  - DONE: done=1; start -> FETCH with pc=0, done cleared.
- fire = (state==FETCH) && (count + inflight < DEPTH). Conservative: a same-cycle pop is not credited.
- fetch_stall = !fire, combinational from registers only.
- On a fire edge: inflight<=1, pc<=pc+1. Without a fire: inflight<=0.
- Memory latency is exactly 1 edge. The cycle after a fire (inflight==1), instr_in is valid and is decoded and pushed at the next edge.
  - If the opcode is not in {0000,0001,0010}, the word is not pushed and illegal<=1.
- Back-to-back fetch: one fire per cycle is sustained while issue_ready=1.
- Queue:
  - Head fields are driven from registered storage.
  - issue_valid = (count != 0).
  - Pop on issue_valid && issue_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap mod DEPTH.
  - A push never occurs when count==DEPTH; this is guaranteed by the fire rule. A push at full is an assertion failure.
- Pop while empty: ignored.
- issue_* fields hold their last value when empty.
- pc after the final fire holds PROG_LEN (no wrap). pc must not exceed 15, so PROG_LEN=16 wraps to 0 but the FSM has already left FETCH.
- flush (priority over all other events, including start):
  - Next edge: state=IDLE, pc=0, count=0, pointers=0, inflight=0.
  - A returning word in that cycle is discarded.
  - done=0; illegal is retained.
- start while in FETCH/DRAIN: ignored.
- rst_n asserted mid-run: immediate return to reset values; in-flight data is discarded.

Decomposition:
- Shared package tomasulo_pkg holds:
  - Opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_MUL=4'b0010.
  - Field bit positions.
  - A decoded-instruction struct {op, rs1, rs2, rd}.
  - FSM state enum {IDLE, FETCH, DRAIN, DONE}.
- One sub-module: fetch_fifo, a parameterised DEPTH-entry synchronous FIFO storing the decoded struct, with push/pop/count/full/empty.
- Instantiate instr_fetch_queue with the memory model; the run program is 0x2123, 0x0345, 0x0267, 0x089A, 0x27AB, 0x1B56.

Test Plan:
- Reset values: rst_n=0 for 3 cycles, then 1 -> fetch_stall=1, pc=0, issue_valid=0, done=0.
- Streaming run: start pulse, issue_ready=1.
  - pc sequences 0..5 on consecutive cycles.
  - First issue_valid two edges after the first fire, showing op=2 rs1=1 rs2=2 rd=3.
  - Then 0/3/4/5, 0/2/6/7, 0/8/9/10, 2/7/10/11, 1/11/5/6.
  - done=1 after the sixth pop.
- Backpressure: issue_ready=0 after start.
  - Exactly 4 fires occur; fetch_stall=1 with count=4 and pc=4.
  - Release ready -> remaining 2 fetched, all 6 issued in order, none lost or duplicated.
- Flush with the queue at count=2 and inflight=1 -> next cycle count=0, issue_valid=0, pc=0, IDLE; the returning word is not enqueued.
- Illegal word: memory slot 2 = 0xF267 -> illegal=1 (sticky), only 5 issues, done still asserted.
- Restart: start in DONE -> a second identical 6-instruction sequence; start pulsed mid-run -> ignored.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo front end: opcodes, instruction field layout,
// the decoded-instruction record and the fetch FSM states.
package tomasulo_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;

  localparam int FIELD_W = 4;
  localparam int OP_LSB  = 12;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 4;
  localparam int RD_LSB  = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
  } decoded_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

  function automatic decoded_t decode(input logic [15:0] instr);
    decoded_t d;
    d.op  = instr[OP_LSB  +: FIELD_W];
    d.rs1 = instr[RS1_LSB +: FIELD_W];
    d.rs2 = instr[RS2_LSB +: FIELD_W];
    d.rd  = instr[RD_LSB  +: FIELD_W];
    return d;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of decoded instructions. The head is held in a
// register so the issue fields are glitch-free and keep their value when empty.
module fetch_fifo
  import tomasulo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  decoded_t         push_data,
  input  logic             pop,
  output decoded_t         head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  decoded_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  decoded_t         head_reg, head_next;
  logic             do_pop;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign count  = count_reg;
  assign head   = head_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    if (clear) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push)   wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      // The new head is either already stored or is the word being written now.
      if (count_next != '0) begin
        if (push && (rd_ptr_next == wr_ptr_reg)) head_next = push_data;
        else                                      head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: drives pc/fetch_stall to a 1-cycle instruction memory,
// decodes the returned word and queues it for issue over valid/ready.
module instr_fetch_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 6,
  parameter int PC_W     = 4,
  parameter int INSTR_W  = 16
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_stall,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         issue_op,
  output logic [3:0]         issue_rs1,
  output logic [3:0]         issue_rs2,
  output logic [3:0]         issue_rd,
  output logic               illegal,
  output logic               done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic             inflight_reg, inflight_next;
  logic             illegal_reg, illegal_next;

  logic             fire, last_fire, push;
  logic [CNT_W:0]   occupancy;
  decoded_t         word, head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign word = decode(instr_in[15:0]);

  // Reserve a slot for the word in flight; a same-cycle pop earns no credit.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_reg);
  assign fire      = (state_reg == FETCH) && (occupancy < (CNT_W+1)'(DEPTH));
  assign last_fire = fire && (pc_reg == PC_W'(PROG_LEN - 1));
  assign push      = inflight_reg && is_legal(word.op) && !flush;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inflight_next = fire;
    illegal_next  = illegal_reg;
    if (inflight_reg && !is_legal(word.op) && !flush) illegal_next = 1'b1;
    if (fire) pc_next = pc_reg + 1'b1;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH:   if (last_fire) state_next = DRAIN;
      DRAIN:   if (!inflight_reg && fifo_empty) state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next    = IDLE;
      pc_next       = '0;
      inflight_next = 1'b0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      inflight_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      illegal_reg  <= illegal_next;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk1),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (word),
    .pop       (issue_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assert property (@(posedge clk1) disable iff (!rst_n) !(push && fifo_full));

  assign pc          = pc_reg;
  assign fetch_stall = !fire;
  assign issue_valid = !fifo_empty;
  assign issue_op    = head.op;
  assign issue_rs1   = head.rs1;
  assign issue_rs2   = head.rs2;
  assign issue_rd    = head.rd;
  assign illegal     = illegal_reg;
  assign done        = (state_reg == DONE);

endmodule
